// File: rtl/regfile_reader_pkg.sv
// Shared types and sizing for the regfile burst reader.
// The state encoding is fixed at two bits so it can be decoded from a debug bus.
package regfile_reader_pkg;

   localparam int unsigned ADDR_NBITS = 2;
   localparam int unsigned NUM_REGS   = 2 ** ADDR_NBITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/regfile_reader_ctr.sv
// Loadable wrapping address counter paired with a remaining-word counter.
// The count is clamped on load so a burst never reads a register twice.
module regfile_reader_ctr
   import regfile_reader_pkg::*;
#(
   parameter int unsigned p_addr_nbits = ADDR_NBITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic                    dec_i,
   input  logic [p_addr_nbits-1:0] base_i,
   input  logic [p_addr_nbits:0]   count_i,
   output logic [p_addr_nbits-1:0] addr_o,
   output logic [p_addr_nbits:0]   remain_o
);

   localparam logic [p_addr_nbits:0] c_num_regs = {1'b1, {p_addr_nbits{1'b0}}};

   logic [p_addr_nbits-1:0] addr_q, addr_d;
   logic [p_addr_nbits:0]   remain_q, remain_d;

   // Next-state: load wins over decrement; the address wraps naturally at its width.
   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      if (load_i) begin
         addr_d   = base_i;
         remain_d = (count_i > c_num_regs) ? c_num_regs : count_i;
      end else if (dec_i) begin
         addr_d   = addr_q + p_addr_nbits'(1);
         remain_d = remain_q - (p_addr_nbits + 1)'(1);
      end else begin
         addr_d   = addr_q;
         remain_d = remain_q;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= {p_addr_nbits{1'b0}};
         remain_q <= {(p_addr_nbits + 1){1'b0}};
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
      end
   end

   assign addr_o   = addr_q;
   assign remain_o = remain_q;

endmodule

// File: rtl/regfile_burst_reader.sv
// Streams a contiguous, wrapping range of regfile words out on a valid/ready port.
// Each word is snapshotted in LOAD and held untouched until the consumer takes it.
module regfile_burst_reader
   import regfile_reader_pkg::*;
#(
   parameter int unsigned p_data_nbits = 4,
   parameter int unsigned p_addr_nbits = ADDR_NBITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [p_addr_nbits-1:0] base,
   input  logic [p_addr_nbits:0]   count,
   output logic [p_addr_nbits-1:0] rf_raddr,
   input  logic [p_data_nbits-1:0] rf_rdata,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [p_data_nbits-1:0] out_data,
   output logic [p_addr_nbits-1:0] out_addr,
   output logic                    busy,
   output logic                    done
);

   localparam logic [p_addr_nbits:0] c_zero_count = {(p_addr_nbits + 1){1'b0}};

   state_e                  state_q;
   logic                    out_val_q;
   logic [p_data_nbits-1:0] out_data_q;
   logic [p_addr_nbits-1:0] out_addr_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    load_s;
   logic                    dec_s;
   logic [p_addr_nbits-1:0] cur_addr_s;
   logic [p_addr_nbits:0]   remain_s;

   assign load_s = (state_q == ST_IDLE) && start;
   assign dec_s  = (state_q == ST_LOAD);

   regfile_reader_ctr #(
      .p_addr_nbits (p_addr_nbits)
   ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load_s),
      .dec_i    (dec_s),
      .base_i   (base),
      .count_i  (count),
      .addr_o   (cur_addr_s),
      .remain_o (remain_s)
   );

   // Burst FSM with the output buffer; remain_s is already decremented by the time SEND decides.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         out_val_q  <= 1'b0;
         out_data_q <= {p_data_nbits{1'b0}};
         out_addr_q <= {p_addr_nbits{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  state_q <= (count == c_zero_count) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               out_data_q <= rf_rdata;
               out_addr_q <= cur_addr_s;
               out_val_q  <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               if (out_rdy) begin
                  out_val_q <= 1'b0;
                  state_q   <= (remain_s != c_zero_count) ? ST_LOAD : ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               out_val_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign rf_raddr = cur_addr_s;
   assign out_val  = out_val_q;
   assign out_data = out_data_q;
   assign out_addr = out_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Self-checking bench for regfile_burst_reader: table-driven bursts plus hand-written
// sequences for count=0 timing, start-while-busy, backpressure and async reset.
module tb_regfile_burst_reader;
   import regfile_reader_pkg::*;

   localparam int DW = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   count;
   logic [AW-1:0] rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic          out_val;
   logic          out_rdy = 1'b0;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          busy;
   logic          done;

   logic [DW-1:0] rf [NUM_REGS];
   assign rf_rdata = rf[rf_raddr];

   regfile_burst_reader #(.p_data_nbits(DW), .p_addr_nbits(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_val(out_val), .out_rdy(out_rdy),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   count;
      int            exp_words;
   } vec_t;

   word_t sb[$];
   vec_t  vecs[6];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int word_cnt = 0;

   logic          rdy_default = 1'b1;
   logic          stall_en = 1'b0;
   logic [AW-1:0] stall_addr = '0;
   int            stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Ready driver: stalls the configured address for 5 cycles and corrupts the regfile mid-stall.
   initial forever begin
      @(posedge clk);
      #1;
      if (stall_en && out_val && out_addr == stall_addr && stall_cnt < 5) begin
         out_rdy = 1'b0;
         stall_cnt++;
         if (stall_cnt == 3) rf[stall_addr] = 4'hF;
      end else begin
         out_rdy = rdy_default;
      end
   end

   // Monitor: scoreboard compare on transfers, stability check while stalled.
   initial begin : monitor
      logic          prev_val;
      logic          prev_rdy;
      logic [DW-1:0] prev_data;
      logic [AW-1:0] prev_addr;
      word_t         w;
      prev_val = 1'b0;
      prev_rdy = 1'b0;
      prev_data = '0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_val = 1'b0;
         end else begin
            if (prev_val && !prev_rdy) begin
               check("stall_val", out_val, 1);
               check("stall_data", out_data, prev_data);
               check("stall_addr", out_addr, prev_addr);
            end
            if (out_val && out_rdy) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 1, 0);
               end else begin
                  w = sb.pop_front();
                  check("word_addr", out_addr, w.addr);
                  check("word_data", out_data, w.data);
               end
               word_cnt++;
               last_xfer_cyc = cyc;
            end
            prev_val = out_val;
            prev_rdy = out_rdy;
            prev_data = out_data;
            prev_addr = out_addr;
         end
      end
   end

   task automatic begin_burst(input logic [AW-1:0] b, input logic [AW:0] c);
      int n;
      word_t w;
      logic [AW-1:0] a;
      @(posedge clk);
      #1;
      word_cnt = 0;
      start = 1'b1;
      base = b;
      count = c;
      n = (c > NUM_REGS) ? NUM_REGS : int'(c);
      for (int i = 0; i < n; i++) begin
         a = b + AW'(i);
         w.addr = a;
         w.data = rf[a];
         sb.push_back(w);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      base = AW'($urandom);
      count = (AW + 1)'($urandom);
   endtask

   task automatic finish_burst(input int exp_words);
      bit seen;
      int dcyc;
      seen = 1'b0;
      dcyc = 0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            dcyc = cyc;
         end else begin
            check("busy_during", busy, 1);
         end
      end
      check("done_seen", seen, 1);
      check("word_count", word_cnt, exp_words);
      check("sb_empty", sb.size(), 0);
      check("busy_after", busy, 0);
      if (exp_words > 0) check("done_latency", dcyc - last_xfer_cyc, 2);
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      start = 1'b0;
      base = '0;
      count = '0;
      rf[0] = 4'h1; rf[1] = 4'h2; rf[2] = 4'h4; rf[3] = 4'h8;
      vecs[0] = '{2'd0, 3'd4, 4};
      vecs[1] = '{2'd3, 3'd3, 3};
      vecs[2] = '{2'd2, 3'd0, 0};
      vecs[3] = '{2'd1, 3'd7, 4};
      vecs[4] = '{2'd2, 3'd5, 4};
      vecs[5] = '{2'd1, 3'd1, 1};

      @(negedge clk);
      check("rst_out_val", out_val, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_raddr", rf_raddr, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", out_addr, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         begin_burst(vecs[i].base, vecs[i].count);
         if (vecs[i].exp_words > 0) begin
            @(negedge clk);
            check("lat_load", out_val, 0);
            @(negedge clk);
            check("lat_send", out_val, 1);
         end
         finish_burst(vecs[i].exp_words);
      end

      // count=0: busy for exactly the DONE cycle, done on the following cycle.
      begin_burst(2'd1, 3'd0);
      @(negedge clk);
      check("zero_done_early", done, 0);
      check("zero_busy", busy, 1);
      check("zero_val", out_val, 0);
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_busy_after", busy, 0);
      @(negedge clk);
      check("zero_done_once", done, 0);

      // start while busy is ignored.
      begin_burst(2'd1, 3'd2);
      @(posedge clk);
      #1;
      start = 1'b1;
      base = 2'd3;
      count = 3'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_burst(2);

      // Backpressure on word at address 2 with regfile change during the stall.
      stall_addr = 2'd2;
      stall_cnt = 0;
      stall_en = 1'b1;
      begin_burst(2'd0, 3'd4);
      finish_burst(4);
      check("stall_cycles", stall_cnt, 5);
      stall_en = 1'b0;
      rf[2] = 4'h4;

      // Async reset while holding a word in SEND.
      rdy_default = 1'b0;
      @(posedge clk);
      #1;
      begin_burst(2'd0, 3'd4);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (out_val) seen = 1'b1;
      end
      check("rst_test_val_seen", seen, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_val", out_val, 0);
      check("arst_busy", busy, 0);
      check("arst_raddr", rf_raddr, 0);
      check("arst_data", out_data, 0);
      check("arst_addr", out_addr, 0);
      sb.delete();
      rdy_default = 1'b1;
      @(negedge clk);
      check("arst_no_done", done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("arst_no_done_after", done, 0);
      begin_burst(2'd0, 3'd4);
      finish_burst(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, reached %0t", $time);
      $fatal(1);
   end

endmodule
